max7219_word_tx: RTL and testbench
==================================

Name: max7219_word_tx

Overview:
Serializer between the display sequencer and a MAX7219 LED driver. It accepts one 16-bit command word (address byte plus data byte) over a valid/ready handshake. It shifts the word out MSB-first on clk_out/data_out, then pulses latch_out to load the word into the driver. It replaces free-running shift logic gated by reset, so the sequencer can stream init and row words back-to-back without its own timing counters.

Parameters:
CLK_DIV, 4, system clocks per clk_out half-period (>=1)
LATCH_HOLD, 1, latch_out high time in half-periods (>=1)
GAP_CYCLES, 8, idle system clocks after latch_out falls before ready_out reasserts (>=0)
CASCADE, 1, number of chained MAX7219 devices; used only when MAX7219_CASCADE_EN is defined

Ports:
clk_in  input  1  system clock
reset_n_in  input  1  synchronous reset, active-low
word_in  input  16 (16*CASCADE with macro)  word to send, sampled on accept
valid_in  input  1  upstream word valid
ready_out  output  1  block can accept a word
clk_out  output  1  serial clock to driver
data_out  output  1  serial data, MSB first
latch_out  output  1  LOAD strobe, rising edge latches word
done_out  output  1  one-cycle pulse when latch_out rises
busy_out  output  1  high from accept until ready_out reasserts

Behaviour:
- Clock and reset: one clock, clk_in. reset_n_in is synchronous and active-low, sampled on the clk_in rising edge.
- Reset values: clk_out=0, data_out=0, latch_out=0, done_out=0, busy_out=0, ready_out=0. ready_out goes 1 on the first edge with reset_n_in high.
- States: IDLE, SHIFT, TAIL, LATCH, GAP.
- Accept: the edge at cycle T with valid_in & ready_out. Capture word_in into the shift register, go to SHIFT. From T+1: ready_out=0, busy_out=1.
- All outputs are registered.
- SHIFT: each bit takes 2*CLK_DIV cycles.
  - Low phase, CLK_DIV cycles: clk_out=0, data_out=current bit.
  - High phase, CLK_DIV cycles: clk_out=1, data_out held.
  - data_out changes only at the start of a low phase.
  - 16 bits (16*CASCADE with macro) occupy cycles T+1 .. T+32*CLK_DIV.
- TAIL: CLK_DIV cycles, clk_out=0, data_out held at the last bit. latch_out stays 0 throughout SHIFT and TAIL.
- LATCH: latch_out=1 for LATCH_HOLD*CLK_DIV cycles, starting at T+1+33*CLK_DIV. done_out=1 in the first LATCH cycle only. data_out returns to 0.
- GAP: GAP_CYCLES cycles with all outputs idle and ready_out=0. Then IDLE: ready_out=1, busy_out=0.
- Defaults (CLK_DIV=4, LATCH_HOLD=1, GAP_CYCLES=8), relative to accept at T:
  - first clk_out rise at T+5
  - latch_out high T+133..T+136
  - done_out at T+133
  - ready_out high at T+145
- Back-to-back: valid_in held high causes acceptance on the first cycle ready_out=1. No combinational path from valid_in to ready_out.
- valid_in and word_in are ignored while not in IDLE. The captured word is immune to word_in changes.
- Reset mid-transfer: the word is abandoned and the outputs take their reset values on that edge. latch_out never rises, so the driver does not load a partial word. No done_out is issued.
- Counters are sized to hold max(CLK_DIV, LATCH_HOLD*CLK_DIV, GAP_CYCLES) and never wrap within a state.

Optional Feature:
MAX7219_CASCADE_EN
- Defined:
  - word_in is 16*CASCADE bits and all bits shift MSB first.
  - One latch pulse follows the final bit, loading every chained device at once.
  - SHIFT length is 32*CASCADE*CLK_DIV cycles; TAIL, LATCH and GAP are unchanged.
- Undefined: CASCADE is ignored, word_in is 16 bits, timing is as above.

Test Plan:
1. reset_n_in low for 3 cycles with valid_in=1, word_in=0xFFFF -> all outputs 0, no accept. ready_out=1 one edge after release.
2. Send 0x0C01 with defaults, accept at T:
   - 16 clk_out rising edges, first at T+5.
   - data_out sampled at the rises reads 0000110000000001.
   - latch_out high T+133..T+136, done_out only at T+133, ready_out at T+145.
3. valid_in held high with 0x0F01 then 0x0F00:
   - second accept exactly at T+145, never earlier.
   - second latch rises at T+278.
4. Toggle word_in every cycle during SHIFT -> serial stream still equals the word captured at accept. No second accept.
5. Assert reset_n_in after the 5th clk_out rise -> latch_out stays 0 throughout, no done_out. After release, a fresh 0x0900 transfers normally.
6. With MAX7219_CASCADE_EN and CASCADE=2, send 0x0C010F00 -> 32 clk_out rises, latch_out rises at T+261, single done_out.

Source files
------------

// File: rtl/max7219_word_tx.sv
`default_nettype none
// max7219_word_tx: valid/ready 16-bit word serializer for a MAX7219 (CLK/DIN/LOAD), rev 1.0.
// Optional MAX7219_CASCADE_EN widens the word to 16*CASCADE bits for daisy-chained drivers.
module max7219_word_tx #(
  parameter int CLK_DIV    = 4,
  parameter int LATCH_HOLD = 1,
  parameter int GAP_CYCLES = 8,
  parameter int CASCADE    = 1
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
`ifdef MAX7219_CASCADE_EN
  input  logic [16*CASCADE-1:0]  word_in,
`else
  input  logic [15:0]            word_in,
`endif
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic                   clk_out,
  output logic                   data_out,
  output logic                   latch_out,
  output logic                   done_out,
  output logic                   busy_out
);

`ifdef MAX7219_CASCADE_EN
  localparam int W = 16 * CASCADE;
`else
  localparam int W = 16;
`endif
  localparam int LATCH_CYC = LATCH_HOLD * CLK_DIV;
  localparam int MAX_A     = (LATCH_CYC > CLK_DIV) ? LATCH_CYC : CLK_DIV;
  localparam int CNT_MAX   = (GAP_CYCLES > MAX_A) ? GAP_CYCLES : MAX_A;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int BW        = $clog2(W);

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [BW-1:0] BITS_LAST  = BW'(W - 1);

  if (CASCADE < 1 || CLK_DIV < 1 || LATCH_HOLD < 1 || GAP_CYCLES < 0) begin : g_param_check
    $error("max7219_word_tx: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_TAIL  = 3'd2,
    S_LATCH = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e          state_q;
  logic [W-1:0]    shreg_q;
  logic [BW-1:0]   bit_cnt_q;
  logic [CW-1:0]   cnt_q;
  logic            clk_q, data_q, latch_q, done_q, busy_q, ready_q;

  // cnt_q holds the cycles left in the current phase; clk_q doubles as the SHIFT phase flag.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      clk_q     <= 1'b0;
      data_q    <= 1'b0;
      latch_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (valid_in && ready_q) begin
            state_q   <= S_SHIFT;
            shreg_q   <= word_in;
            data_q    <= word_in[W-1];
            bit_cnt_q <= BITS_LAST;
            cnt_q     <= DIV_LAST;
            clk_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            cnt_q <= DIV_LAST;
            if (!clk_q) begin
              clk_q <= 1'b1;
            end else begin
              clk_q <= 1'b0;
              if (bit_cnt_q == '0) begin
                state_q <= S_TAIL;
              end else begin
                bit_cnt_q <= bit_cnt_q - 1'b1;
                data_q    <= shreg_q[W-2];
                shreg_q   <= shreg_q << 1;
              end
            end
          end
        end
        S_TAIL: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= S_LATCH;
            latch_q <= 1'b1;
            done_q  <= 1'b1;
            data_q  <= 1'b0;
            cnt_q   <= LATCH_LAST;
          end
        end
        S_LATCH: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            latch_q <= 1'b0;
            if (GAP_CYCLES == 0) begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_GAP;
              cnt_q   <= GAP_LAST;
            end
          end
        end
        S_GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_out = ready_q;
  assign clk_out   = clk_q;
  assign data_out  = data_q;
  assign latch_out = latch_q;
  assign done_out  = done_q;
  assign busy_out  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_max7219_word_tx.sv
`default_nettype none
// tb_max7219_word_tx: vector table plus random words, checked every cycle against a
// reference model that derives each output from the cycle offset since accept.
module tb_max7219_word_tx;
  localparam int D  = 4;
  localparam int LH = 1;
  localparam int G  = 8;
`ifdef MAX7219_CASCADE_EN
  localparam int CASC = 2;
`else
  localparam int CASC = 1;
`endif
  localparam int W         = 16 * CASC;
  localparam int SHIFT_CYC = 2 * W * D;
  localparam int LATCH_OFF = 1 + SHIFT_CYC + D;
  localparam int READY_OFF = LATCH_OFF + LH * D + G;
  localparam int MAX_WAIT  = 2 * READY_OFF;

  logic         clk = 1'b0;
  logic         reset_n_in = 1'b0;
  logic         valid_in = 1'b0;
  logic [W-1:0] word_in = '1;
  logic         ready_out, clk_out, data_out, latch_out, done_out, busy_out;

  max7219_word_tx #(
    .CLK_DIV(D), .LATCH_HOLD(LH), .GAP_CYCLES(G), .CASCADE(CASC)
  ) dut (
    .clk_in(clk), .reset_n_in(reset_n_in), .word_in(word_in), .valid_in(valid_in),
    .ready_out(ready_out), .clk_out(clk_out), .data_out(data_out),
    .latch_out(latch_out), .done_out(done_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_t = 0;

  bit           m_rst = 1'b1;
  bit           m_tx = 1'b0;
  int           m_t = 0;
  logic [W-1:0] m_word = '0;

  int           rises, first_rise, latch_cnt, latch_cyc, done_cnt, done_cyc;
  logic [W-1:0] bits;
  logic         prev_clk = 1'b0;
  logic         prev_latch = 1'b0;

  typedef struct {
    logic [W-1:0] word;
    bit           toggle;
    bit           keep;
    bit           b2b;
    int           rst_rise;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [W-1:0] w, input bit tg, input bit kp,
                              input bit bb, input int rr);
    vec_t v;
    v.word = w; v.toggle = tg; v.keep = kp; v.b2b = bb; v.rst_rise = rr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // {ready, busy, clk, data, latch, done} expected in the current cycle
  function automatic logic [5:0] model_out();
    int k;
    logic c, d, l, dn;
    if (m_rst) return 6'b000000;
    if (!m_tx) return 6'b100000;
    k = cyc - m_t;
    c = 1'b0; d = 1'b0; l = 1'b0; dn = 1'b0;
    if (k <= SHIFT_CYC) begin
      c = (((k - 1) % (2 * D)) >= D);
      d = m_word[W - 1 - (k - 1) / (2 * D)];
    end else if (k <= SHIFT_CYC + D) begin
      d = m_word[0];
    end else if (k < LATCH_OFF + LH * D) begin
      l = 1'b1;
      dn = (k == LATCH_OFF);
    end
    return {1'b0, 1'b1, c, d, l, dn};
  endfunction

  task automatic monitor_step();
    if (m_tx && (cyc - m_t) >= READY_OFF) m_tx = 1'b0;
    check("model", {58'd0, ready_out, busy_out, clk_out, data_out, latch_out, done_out},
          {58'd0, model_out()});
    if (clk_out && !prev_clk) begin
      if (rises == 0) first_rise = cyc;
      bits = {bits[W-2:0], data_out};
      rises++;
    end
    if (latch_out && !prev_latch) begin
      latch_cnt++;
      latch_cyc = cyc;
    end
    if (done_out) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_clk = clk_out;
    prev_latch = latch_out;
    if (!reset_n_in) begin
      m_rst = 1'b1;
      m_tx = 1'b0;
    end else begin
      if (!m_rst && !m_tx && valid_in) begin
        m_tx = 1'b1;
        m_t = cyc;
        m_word = word_in;
      end
      m_rst = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_logs();
    rises = 0; first_rise = -1; latch_cnt = 0; latch_cyc = -1;
    done_cnt = 0; done_cyc = -1; bits = '0;
  endtask

  task automatic run_vec(input vec_t v);
    int  n;
    int  t;
    bit  rst_done;
    word_in = v.word;
    valid_in = 1'b1;
    n = 0;
    while (!ready_out && n < MAX_WAIT) begin
      tick();
      n++;
    end
    if (!ready_out) begin
      check("accept_timeout", 64'd0, 64'd1);
      valid_in = 1'b0;
      return;
    end
    t = cyc;
    clear_logs();
    if (v.b2b) check("b2b_accept", t - prev_t, READY_OFF);
    tick();
    if (!v.keep) valid_in = 1'b0;
    rst_done = 1'b0;
    while (cyc < t + READY_OFF) begin
      if (v.toggle) word_in = W'({$urandom(), $urandom()});
      if (v.rst_rise > 0 && !rst_done && rises == v.rst_rise) begin
        rst_done = 1'b1;
        reset_n_in = 1'b0;
        tick();
        tick();
        reset_n_in = 1'b1;
      end else begin
        tick();
      end
    end
    if (v.rst_rise > 0) begin
      check("rst_no_latch", latch_cnt, 0);
      check("rst_no_done", done_cnt, 0);
      check("rst_ready", ready_out, 1'b1);
    end else begin
      check("rises", rises, W);
      check("bits", bits, v.word);
      check("first_rise", first_rise - t, D + 1);
      check("latch_rise", latch_cyc - t, LATCH_OFF);
      check("latch_cnt", latch_cnt, 1);
      check("done_cnt", done_cnt, 1);
      check("done_at", done_cyc - t, LATCH_OFF);
      check("ready_back", ready_out, 1'b1);
    end
    prev_t = t;
  endtask

  initial begin
    vt.push_back(mk(W'(16'h0C01), 1'b0, 1'b0, 1'b0, 0));
    vt.push_back(mk(W'(16'h0F01), 1'b0, 1'b1, 1'b0, 0));
    vt.push_back(mk(W'(16'h0F00), 1'b0, 1'b0, 1'b1, 0));
    vt.push_back(mk(W'(16'h5A3C), 1'b1, 1'b1, 1'b0, 0));
    vt.push_back(mk(W'(16'hA5F0), 1'b0, 1'b0, 1'b0, 5));
    vt.push_back(mk(W'(16'h0900), 1'b0, 1'b0, 1'b0, 0));
`ifdef MAX7219_CASCADE_EN
    vt.push_back(mk(W'(32'h0C010F00), 1'b0, 1'b0, 1'b0, 0));
`endif

    reset_n_in = 1'b0;
    valid_in = 1'b1;
    word_in = '1;
    @(posedge clk);
    #1;
    cyc = 1;
    tick();
    tick();
    check("reset_outs", {58'd0, ready_out, busy_out, clk_out, data_out, latch_out, done_out}, 64'd0);
    reset_n_in = 1'b1;
    valid_in = 1'b0;
    tick();
    check("ready_after_release", ready_out, 1'b1);
    check("busy_after_release", busy_out, 1'b0);
    clear_logs();

    foreach (vt[i]) run_vec(vt[i]);

    for (int i = 0; i < 6; i++) begin
      vec_t v;
      repeat ($urandom_range(0, 3)) tick();
      v = mk(W'({$urandom(), $urandom()}), 1'(($urandom_range(0, 1))), 1'b0, 1'b0,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : 0);
      run_vec(v);
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
